instrumented_ro_sequencer: RTL and testbench
============================================

INSTRUMENTED_RO_SEQUENCER -- requirements
Module: instrumented_ro_sequencer

Interface
REQ-001 Parameter CFG_BITS, default 16: length of the serial configuration word shifted into the oscillator.
REQ-002 Parameter BCLK_HALF, default 2: clk cycles per bclk half-period; legal range 1..15.
REQ-003 Parameter SETTLE_CYCLES, default 3: clk cycles hold is asserted before phase capture; minimum 3.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  single-cycle request to run one measurement; sampled only in IDLE.
REQ-007 cfg_word  in  CFG_BITS  serial config, latched on accepted start.
REQ-008 cfg_stages  in  4  stage-count select, latched on accepted start.
REQ-009 gate_cycles  in  8  oscillation window length in clk cycles, latched on accepted start.
REQ-010 busy  out  1  high from cycle after accepted start until return to IDLE.
REQ-011 result  out  16  captured phase snapshot.
REQ-012 result_valid  out  1  result available; held until result_ready.
REQ-013 result_ready  in  1  consumer accepts result when high with result_valid.
REQ-014 ro_enable, ro_hold, ro_bdat, ro_bclk  out  1 each  oscillator enable, freeze, serial data, serial clock.
REQ-015 ro_n_stages  out  4  stage-count select to oscillator.
REQ-016 ro_phases  in  16  oscillator phase taps; asynchronous to clk.

Function
REQ-017 FSM states IDLE, SHIFT, RUN, FREEZE, CAPTURE, OUT; encoding is implementation choice.
REQ-018 IDLE: start=1 latches cfg_word, cfg_stages, gate_cycles and moves to SHIFT next cycle; start in any other state is ignored.
REQ-019 ro_n_stages drives the latched cfg_stages from SHIFT entry until IDLE re-entry; 0 in IDLE.
REQ-020 SHIFT: CFG_BITS bits sent MSB first; per bit, ro_bdat valid whole bit period, ro_bclk low BCLK_HALF cycles then high BCLK_HALF cycles; SHIFT lasts exactly CFG_BITS*2*BCLK_HALF cycles.
REQ-021 ro_bclk and ro_bdat are 0 outside SHIFT; both registered outputs, no glitches.
REQ-022 RUN: ro_enable=1 for exactly gate_cycles cycles; gate_cycles=0 skips RUN and ro_enable never asserts in that measurement.
REQ-023 FREEZE: ro_hold=1 for SETTLE_CYCLES cycles, ro_enable stays at its RUN value; ro_phases sampled through a 2-flop synchronizer running continuously.
REQ-024 CAPTURE: one cycle; synchronizer output loaded into result; ro_hold and ro_enable go 0 next cycle.
REQ-025 OUT: result_valid=1, result stable until cycle where result_ready=1; then IDLE next cycle, result_valid=0.
REQ-026 result_ready while result_valid=0 has no effect; result retains last value until next CAPTURE.
REQ-027 busy=1 in every state except IDLE; busy and result_valid both 0 in IDLE.
REQ-028 Total latency start to result_valid = 1 + CFG_BITS*2*BCLK_HALF + gate_cycles + SETTLE_CYCLES + 1 cycles.

Reset
REQ-029 rst_n low, at any time incl. mid-SHIFT or mid-RUN: FSM to IDLE immediately, all outputs 0, result 0, counters and synchronizer cleared.
REQ-030 Outputs remain 0 after rst_n release until first accepted start.

Structure
REQ-031 Shared package holds FSM state enum, default CFG_BITS/BCLK_HALF/SETTLE_CYCLES, phase width 16.
REQ-032 One sub-module, iro_serial_tx: parameterised MSB-first bit shifter generating bdat/bclk with done pulse.
REQ-033 Synchronizer is a plain 2-flop per bit; no combinational path from ro_phases to any output.

Verification
REQ-034 cfg_word=0xA5C3, BCLK_HALF=2, start -> 16 bclk pulses, bdat sequence 1010010111000011 sampled on bclk rise, SHIFT = 64 cycles.
REQ-035 gate_cycles=10, ro_phases=0x1234 constant -> ro_enable high exactly 10 cycles, result=0x1234, result_valid at cycle 1+64+10+3+1=79 after start.
REQ-036 gate_cycles=0 -> ro_enable never high; result_valid at cycle 69; ro_hold high exactly 3 cycles.
REQ-037 result_ready held low 20 cycles in OUT, start pulsed meanwhile -> result_valid and result stable, start ignored, IDLE one cycle after result_ready=1.
REQ-038 rst_n low during bit 7 of SHIFT -> all outputs 0 same cycle; after release, new start runs full 16-bit shift from MSB.
REQ-039 cfg_stages=0xB -> ro_n_stages=0xB from SHIFT entry to OUT exit, 0 in IDLE.

Source files
------------

// File: rtl/instrumented_ro_sequencer_pkg.sv
// Shared types and default parameters for the instrumented ring-oscillator sequencer.
package instrumented_ro_sequencer_pkg;

    localparam int unsigned DEF_CFG_BITS      = 16;
    localparam int unsigned DEF_BCLK_HALF     = 2;
    localparam int unsigned DEF_SETTLE_CYCLES = 3;
    localparam int unsigned PHASE_W           = 16;
    localparam int unsigned STAGES_W          = 4;
    localparam int unsigned GATE_W            = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_RUN,
        ST_FREEZE,
        ST_CAPTURE,
        ST_OUT
    } seq_state_t;

    // Measurement settings captured when a start request is accepted.
    typedef struct packed {
        logic [STAGES_W-1:0] stages;
        logic [GATE_W-1:0]   gate;
    } meas_cfg_t;

endpackage

// File: rtl/instrumented_ro_sequencer_if.sv
// Host request/result handshake plus oscillator control and phase-tap bundle.
interface instrumented_ro_sequencer_if #(
    parameter int unsigned CFG_BITS = instrumented_ro_sequencer_pkg::DEF_CFG_BITS
);
    import instrumented_ro_sequencer_pkg::*;

    logic                start;
    logic [CFG_BITS-1:0] cfg_word;
    logic [STAGES_W-1:0] cfg_stages;
    logic [GATE_W-1:0]   gate_cycles;
    logic                busy;
    logic [PHASE_W-1:0]  result;
    logic                result_valid;
    logic                result_ready;
    logic                ro_enable;
    logic                ro_hold;
    logic                ro_bdat;
    logic                ro_bclk;
    logic [STAGES_W-1:0] ro_n_stages;
    logic [PHASE_W-1:0]  ro_phases;

    // Host / oscillator model side.
    modport master (
        output start, cfg_word, cfg_stages, gate_cycles, result_ready, ro_phases,
        input  busy, result, result_valid, ro_enable, ro_hold, ro_bdat, ro_bclk, ro_n_stages
    );

    // Sequencer side.
    modport slave (
        input  start, cfg_word, cfg_stages, gate_cycles, result_ready, ro_phases,
        output busy, result, result_valid, ro_enable, ro_hold, ro_bdat, ro_bclk, ro_n_stages
    );

endinterface

// File: rtl/iro_serial_tx.sv
// MSB-first serial shifter: per bit, bclk low HALF cycles then high HALF cycles, bdat held.
module iro_serial_tx #(
    parameter int unsigned BITS = 16,
    parameter int unsigned HALF = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [BITS-1:0] word,
    output logic            bdat,
    output logic            bclk,
    output logic            done_c
);
    localparam int unsigned PH_W  = $clog2(2 * HALF);
    localparam int unsigned BIT_W = $clog2(BITS + 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * HALF - 1);
    localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(HALF);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);

    logic [BITS-1:0]  sh_q;
    logic [PH_W-1:0]  ph_q;
    logic [BIT_W-1:0] bit_q;
    logic             active_q;
    logic             bclk_q;

    // Shifting out all BITS bits leaves the register zero, so bdat idles low by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= '0;
            ph_q     <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
            bclk_q   <= 1'b0;
        end else if (load) begin
            sh_q     <= word;
            ph_q     <= '0;
            bit_q    <= '0;
            active_q <= 1'b1;
            bclk_q   <= 1'b0;
        end else if (active_q) begin
            if (ph_q == PH_LAST) begin
                ph_q   <= '0;
                bclk_q <= 1'b0;
                sh_q   <= sh_q << 1;
                if (bit_q == BIT_LAST) begin
                    active_q <= 1'b0;
                end else begin
                    bit_q <= bit_q + BIT_W'(1);
                end
            end else begin
                ph_q   <= ph_q + PH_W'(1);
                bclk_q <= ((ph_q + PH_W'(1)) >= PH_HIGH);
            end
        end
    end

    assign bdat   = sh_q[BITS-1];
    assign bclk   = bclk_q;
    assign done_c = active_q && (ph_q == PH_LAST) && (bit_q == BIT_LAST);

endmodule

// File: rtl/instrumented_ro_sequencer.sv
// Configures a ring oscillator serially, runs it for a gate window, freezes and snapshots its phases.
module instrumented_ro_sequencer
    import instrumented_ro_sequencer_pkg::*;
#(
    parameter int unsigned CFG_BITS      = DEF_CFG_BITS,
    parameter int unsigned BCLK_HALF     = DEF_BCLK_HALF,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    instrumented_ro_sequencer_if.slave   bus
);
    localparam logic [GATE_W-1:0] SETTLE_LAST = GATE_W'(SETTLE_CYCLES - 1);

    seq_state_t          state_q, state_d;
    meas_cfg_t           cfg_q, cfg_d;
    logic [GATE_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0]  result_q, result_d;
    logic [PHASE_W-1:0]  sync_meta, sync_out;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                enable_q, enable_d;
    logic                hold_q, hold_d;
    logic [STAGES_W-1:0] stages_q, stages_d;
    logic                tx_load_c;
    logic                tx_done_c;
    logic                tx_bdat;
    logic                tx_bclk;

    assign tx_load_c = (state_q == ST_IDLE) && bus.start;

    iro_serial_tx #(
        .BITS (CFG_BITS),
        .HALF (BCLK_HALF)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tx_load_c),
        .word   (bus.cfg_word),
        .bdat   (tx_bdat),
        .bclk   (tx_bclk),
        .done_c (tx_done_c)
    );

    // Phase taps are asynchronous; plain two-flop synchronizer, always running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= bus.ro_phases;
            sync_out  <= sync_meta;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cfg_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            enable_q <= 1'b0;
            hold_q   <= 1'b0;
            stages_q <= '0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            enable_q <= enable_d;
            hold_q   <= hold_d;
            stages_q <= stages_d;
        end
    end

    // Next state; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cfg_d.stages = bus.cfg_stages;
                    cfg_d.gate   = bus.gate_cycles;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tx_done_c) begin
                    cnt_d   = '0;
                    state_d = (cfg_q.gate == '0) ? ST_FREEZE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == (cfg_q.gate - GATE_W'(1))) begin
                    cnt_d   = '0;
                    state_d = ST_FREEZE;
                end else begin
                    cnt_d = cnt_q + GATE_W'(1);
                end
            end
            ST_FREEZE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + GATE_W'(1);
                end
            end
            ST_CAPTURE: begin
                result_d = sync_out;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (bus.result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d   = (state_d != ST_IDLE);
        valid_d  = (state_d == ST_OUT);
        enable_d = (state_d == ST_RUN);
        hold_d   = (state_d == ST_FREEZE);
        stages_d = (state_d != ST_IDLE) ? cfg_d.stages : '0;
    end

    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.ro_enable    = enable_q;
    assign bus.ro_hold      = hold_q;
    assign bus.ro_bdat      = tx_bdat;
    assign bus.ro_bclk      = tx_bclk;
    assign bus.ro_n_stages  = stages_q;

endmodule

// File: tb/tb_instrumented_ro_sequencer.sv
// Randomized scoreboard bench: driver pushes expected measurements, negedge monitor checks them.
module tb_instrumented_ro_sequencer;
    import instrumented_ro_sequencer_pkg::*;

    localparam int unsigned CFG_BITS      = 16;
    localparam int unsigned BCLK_HALF     = 2;
    localparam int unsigned SETTLE_CYCLES = 3;
    localparam int          SHIFT_LEN     = CFG_BITS * 2 * BCLK_HALF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instrumented_ro_sequencer_if #(.CFG_BITS(CFG_BITS)) bus ();

    instrumented_ro_sequencer #(
        .CFG_BITS      (CFG_BITS),
        .BCLK_HALF     (BCLK_HALF),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [CFG_BITS-1:0] word;
        int                  gate;
        logic [3:0]          stages;
        logic [15:0]         phases;
        int                  start_cyc;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   n_pushed  = 0;
    int   meas_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic                prev_busy = 1'b0, prev_valid = 1'b0, prev_bclk = 1'b0;
    int                  lat, bit_n, en_cnt, en_first, hold_cnt, hold_first, last_bclk, ready_lat;
    logic [CFG_BITS-1:0] bits_acc;
    logic [3:0]          stg_first;
    bit                  stg_var, out_bad, idle_bad;
    logic [15:0]         held_res, last_res = 16'h0;
    exp_t                cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy  = 1'b0;
            prev_valid = 1'b0;
            prev_bclk  = 1'b0;
            idle_bad   = 1'b0;
            last_res   = 16'h0;
        end else begin
            if (!bus.busy) begin
                if (bus.result_valid || bus.ro_enable || bus.ro_hold || bus.ro_bdat ||
                    bus.ro_bclk || (bus.ro_n_stages != 4'h0) || (bus.result !== last_res))
                    idle_bad = 1'b1;
            end
            if (bus.busy && !prev_busy) begin
                check("idle_outputs", 64'(idle_bad), 64'd0);
                idle_bad  = 1'b0;
                lat       = 1;
                bit_n     = 0;
                bits_acc  = '0;
                en_cnt    = 0;
                en_first  = -1;
                hold_cnt  = 0;
                hold_first = -1;
                last_bclk = -1;
                stg_first = bus.ro_n_stages;
                stg_var   = 1'b0;
                out_bad   = 1'b0;
                ready_lat = -1;
            end else if (bus.busy) begin
                lat++;
            end
            if (bus.busy) begin
                if (bus.ro_n_stages != stg_first) stg_var = 1'b1;
                if (bus.ro_bclk && !prev_bclk) begin
                    bits_acc = {bits_acc[CFG_BITS-2:0], bus.ro_bdat};
                    bit_n++;
                end
                if (bus.ro_bclk) last_bclk = lat;
                if (bus.ro_enable) begin
                    en_cnt++;
                    if (en_first < 0) en_first = lat;
                end
                if (bus.ro_hold) begin
                    hold_cnt++;
                    if (hold_first < 0) hold_first = lat;
                end
                if (bus.result_valid && !prev_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        cur = q.pop_front();
                        check("latency", 64'(cyc - cur.start_cyc + 1),
                              64'(2 + SHIFT_LEN + cur.gate + int'(SETTLE_CYCLES)));
                        check("busy_start", 64'(lat), 64'(cyc - cur.start_cyc + 1));
                        check("result", 64'(bus.result), 64'(cur.phases));
                        check("bdat_seq", 64'(bits_acc), 64'(cur.word));
                        check("bclk_pulses", 64'(bit_n), 64'(CFG_BITS));
                        check("shift_end", 64'(last_bclk), 64'(SHIFT_LEN));
                        check("enable_cycles", 64'(en_cnt), 64'(cur.gate));
                        check("enable_first", 64'(en_first),
                              64'((cur.gate > 0) ? SHIFT_LEN + 1 : -1));
                        check("hold_cycles", 64'(hold_cnt), 64'(SETTLE_CYCLES));
                        check("hold_first", 64'(hold_first), 64'(SHIFT_LEN + cur.gate + 1));
                        check("n_stages", 64'(stg_first), 64'(cur.stages));
                    end
                    held_res = bus.result;
                    last_res = bus.result;
                end
                if (bus.result_valid && (bus.result !== held_res)) out_bad = 1'b1;
                if (bus.result_valid && bus.result_ready) ready_lat = lat;
            end
            if (!bus.busy && prev_busy) begin
                check("idle_after_ready", 64'(ready_lat), 64'(lat));
                check("out_stable", 64'({out_bad, stg_var}), 64'd0);
                meas_done++;
            end
            prev_busy  = bus.busy;
            prev_valid = bus.result_valid;
            prev_bclk  = bus.ro_bclk;
        end
    end

    // ---------------- driver ----------------
    function automatic logic [63:0] all_outputs();
        return 64'({bus.busy, bus.result_valid, bus.result, bus.ro_enable, bus.ro_hold,
                    bus.ro_bdat, bus.ro_bclk, bus.ro_n_stages});
    endfunction

    task automatic wait_idle(output bit ok);
        int t = 0;
        while (bus.busy && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        ok = !bus.busy;
        if (!ok) check("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue_start(input logic [CFG_BITS-1:0] word, input int gate,
                               input logic [3:0] stg, input logic [15:0] ph);
        bus.cfg_word    = word;
        bus.gate_cycles = 8'(gate);
        bus.cfg_stages  = stg;
        bus.ro_phases   = ph;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start       = 1'b0;
        // Scramble inputs to show the sequencer works from latched copies.
        bus.cfg_word    = CFG_BITS'($urandom);
        bus.cfg_stages  = 4'($urandom);
        bus.gate_cycles = 8'($urandom);
    endtask

    task automatic run_meas(input logic [CFG_BITS-1:0] word, input int gate, input logic [3:0] stg,
                            input logic [15:0] ph, input int rdy_delay, input bit poke_start);
        bit   ok;
        int   t;
        exp_t e;
        wait_idle(ok);
        if (!ok) return;
        issue_start(word, gate, stg, ph);
        e.word = word; e.gate = gate; e.stages = stg; e.phases = ph; e.start_cyc = cyc;
        q.push_back(e);
        n_pushed++;
        t = 0;
        while (!bus.result_valid && t < 2000) begin
            @(posedge clk); #1;
            t++;
            if (!bus.result_valid) bus.result_ready = 1'($urandom);
        end
        bus.result_ready = 1'b0;
        if (!bus.result_valid) begin
            check("valid_timeout", 64'd1, 64'd0);
            return;
        end
        for (int i = 0; i < rdy_delay; i++) begin
            if (poke_start && (i == rdy_delay / 2)) bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
    endtask

    task automatic reset_mid_shift();
        bit ok;
        wait_idle(ok);
        if (!ok) return;
        issue_start(CFG_BITS'(16'h5A3C), 12, 4'h7, 16'hBEEF);
        // Now in cycle 1; cycle 31 lies inside bit 7 (cycles 29..32).
        repeat (30) @(posedge clk);
        #1;
        check("busy_before_reset", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_shift_outputs", all_outputs(), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("outputs_after_release", all_outputs(), 64'd0);
    endtask

    initial begin
        bit ok;
        bus.start        = 1'b0;
        bus.cfg_word     = '0;
        bus.cfg_stages   = '0;
        bus.gate_cycles  = '0;
        bus.result_ready = 1'b0;
        bus.ro_phases    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_release_outputs", all_outputs(), 64'd0);

        run_meas(CFG_BITS'(16'hA5C3), 10, 4'hB, 16'h1234, 0, 1'b0);
        run_meas(CFG_BITS'($urandom), 0, 4'($urandom), 16'($urandom), 2, 1'b0);
        run_meas(CFG_BITS'($urandom), 5, 4'($urandom), 16'($urandom), 20, 1'b1);
        for (int i = 0; i < 6; i++)
            run_meas(CFG_BITS'($urandom), int'($urandom_range(0, 40)), 4'($urandom),
                     16'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
        run_meas(CFG_BITS'($urandom), 255, 4'hF, 16'hFFFF, 1, 1'b0);
        reset_mid_shift();
        run_meas(CFG_BITS'(16'hA5C3), 3, 4'h2, 16'h8001, 0, 1'b0);

        wait_idle(ok);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(q.size()), 64'd0);
        check("measurements_completed", 64'(meas_done), 64'(n_pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
